// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin computed LSB first through a single full-adder
// cell and one carry flop, taking WIDTH clock edges per addition.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] res_shift;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic             accept;

  // Returns {carry_out, sum_bit} of one full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  always_comb begin
    {fa_c, fa_s} = full_add(a_sr[0], b_sr[0], carry);
    a_shift   = a_sr >> 1;
    b_shift   = b_sr >> 1;
    // The new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    res_shift = res_sr >> 1;
    res_shift[WIDTH-1] = fa_s;
    last_bit  = (bit_cnt == LAST_BIT);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      res_sr  <= '0;
      bit_cnt <= '0;
      carry   <= cin;
    end else if (state == RUN) begin
      a_sr    <= a_shift;
      b_sr    <= b_shift;
      res_sr  <= res_shift;
      bit_cnt <= bit_cnt + CNT_W'(1);
      carry   <= fa_c;
      // Result registers update only on the final bit so they hold through RUN.
      if (last_bit) begin
        sum  <= res_shift;
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder, with WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // One WIDTH=8 addition with cycle-exact busy/done/hold checks.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    logic [8:0] expv;
    expv = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || {cout, sum} !== {prev_cout, prev_sum}) begin
        fails++;
        $display("FAIL run_cycle%0d %h+%h+%b: busy=%b done=%b res=%h, want busy=1 done=0 res=%h",
                 k, av, bv, ci, busy, done, {cout, sum}, {prev_cout, prev_sum});
      end
      @(posedge clk); #1;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== expv) begin
      fails++;
      $display("FAIL run_result %h+%h+%b: done=%b busy=%b res=%h, want done=1 busy=0 res=%h",
               av, bv, ci, done, busy, {cout, sum}, expv);
    end
    prev_sum  = expv[7:0];
    prev_cout = expv[8];
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== expv) begin
      fails++;
      $display("FAIL run_after %h+%h+%b: done=%b busy=%b res=%h, want done=0 busy=0 res=%h",
               av, bv, ci, done, busy, {cout, sum}, expv);
    end
  endtask

  task automatic test_reset;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      fails++;
      $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b, want all 0", busy1, done1, sum1, cout1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    run8(8'h00, 8'h00, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1);
    run8(8'h3C, 8'h42, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h80, 8'h7F, 1'b0);
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ignore_busy: busy=%b, want 1", busy);
    end
    for (int k = 4; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
      if (k == 8) begin
        tests++;
        if (done !== 1'b1 || {cout, sum} !== 9'h030) begin
          fails++;
          $display("FAIL ignore_result: done=%b res=%h, want done=1 res=030", done, {cout, sum});
        end
      end
    end
    tests++;
    if (dones != 1 || {cout, sum} !== 9'h030) begin
      fails++;
      $display("FAIL ignore_single_done: dones=%0d res=%h, want 1 and 030", dones, {cout, sum});
    end
    prev_sum = 8'h30; prev_cout = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    a = 8'h3C; b = 8'h42; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || {cout, sum} !== 9'h07E) begin
      fails++;
      $display("FAIL b2b_first: done=%b res=%h, want done=1 res=07E", done, {cout, sum});
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_rerun: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    for (int k = 10; k <= 16; k++) begin
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || {cout, sum} !== 9'h07E) begin
        fails++;
        $display("FAIL b2b_run%0d: busy=%b done=%b res=%h, want 1 0 07E", k, busy, done, {cout, sum});
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b1 || {cout, sum} !== 9'h002) begin
      fails++;
      $display("FAIL b2b_second: done=%b res=%h, want done=1 res=002", done, {cout, sum});
    end
    @(posedge clk); #1;
    prev_sum = 8'h02; prev_cout = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int dones;
    dones = 0;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    tests++;
    if (dones != 0 || busy !== 1'b0 || sum !== 8'h00) begin
      fails++;
      $display("FAIL midrun_no_done: dones=%0d busy=%b sum=%h, want 0 0 00", dones, busy, sum);
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
    run8(8'h0F, 8'hF1, 1'b1);
  endtask

  task automatic test_width1;
    logic [1:0] expv;
    for (int i = 0; i < 8; i++) begin
      expv = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      tests++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        fails++;
        $display("FAIL w1_busy case%0d: busy=%b done=%b, want 1 0", i, busy1, done1);
      end
      @(posedge clk); #1;
      tests++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, sum1} !== expv) begin
        fails++;
        $display("FAIL w1_result case%0d: done=%b res=%b, want done=1 res=%b", i, done1, {cout1, sum1}, expv);
      end
      @(posedge clk); #1;
      tests++;
      if (done1 !== 1'b0) begin
        fails++;
        $display("FAIL w1_pulse case%0d: done=%b, want 0", i, done1);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] r;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom;
      run8(r[7:0], r[15:8], r[16]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    test_reset;
    test_vectors;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_width1;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
